// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like bus between the IF and EXE/MEM ports.
// The address channel is granted combinationally (data over inst, or to the
// locked owner of a stalled request) and an in-order owner FIFO steers each
// returning data_ok/rdata beat back to the port that issued it.
module sram_like_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = 3
) (
  input  logic              clk,
  input  logic              resetn,
  // IF port
  input  logic              inst_sram_req,
  input  logic              inst_sram_wr,
  input  logic [1:0]        inst_sram_size,
  input  logic [3:0]        inst_sram_wstrb,
  input  logic [31:0]       inst_sram_addr,
  input  logic [31:0]       inst_sram_wdata,
  output logic              inst_sram_addr_ok,
  output logic              inst_sram_data_ok,
  output logic [31:0]       inst_sram_rdata,
  // EXE/MEM port
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [3:0]        data_sram_wstrb,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [31:0]       data_sram_rdata,
  // shared bus
  output logic              sram_req,
  output logic              sram_wr,
  output logic [1:0]        sram_size,
  output logic [3:0]        sram_wstrb,
  output logic [31:0]       sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic              sram_addr_ok,
  input  logic              sram_data_ok,
  input  logic [31:0]       sram_rdata,
  // status
  output logic [CNT_W-1:0]  outstanding,
  output logic              err_unexp_rsp
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic        SEL_INST = 1'b0;
  localparam logic        SEL_DATA = 1'b1;

  logic                       r_lock;
  logic                       r_locked_sel;
  logic [MAX_OUTSTANDING-1:0] r_owner;
  logic [PTR_W-1:0]           r_wptr;
  logic [PTR_W-1:0]           r_rptr;
  logic [CNT_W-1:0]           r_count;
  logic                       r_err;

  logic w_full;
  logic w_empty;
  logic w_sel;
  logic w_req;
  logic w_push;
  logic w_pop;
  logic w_head;

  // Owner FIFO pointers wrap at MAX_OUTSTANDING, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Grant, occupancy and handshake decode.
  always_comb begin
    w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
    w_empty = (r_count == '0);
    w_sel   = r_lock ? r_locked_sel : (data_sram_req ? SEL_DATA : SEL_INST);
    // Full is judged on the registered count, so a same-cycle pop cannot
    // re-open the request channel until the next cycle.
    w_req   = (inst_sram_req | data_sram_req) & ~w_full;
    w_push  = w_req & sram_addr_ok;
    w_pop   = sram_data_ok & ~w_empty;
    w_head  = r_owner[r_rptr];
  end

  // Shared-bus mux and per-port steering; handshakes are held low in reset.
  always_comb begin
    sram_req          = w_req & resetn;
    sram_wr           = (w_sel == SEL_DATA) ? data_sram_wr    : inst_sram_wr;
    sram_size         = (w_sel == SEL_DATA) ? data_sram_size  : inst_sram_size;
    sram_wstrb        = (w_sel == SEL_DATA) ? data_sram_wstrb : inst_sram_wstrb;
    sram_addr         = (w_sel == SEL_DATA) ? data_sram_addr  : inst_sram_addr;
    sram_wdata        = (w_sel == SEL_DATA) ? data_sram_wdata : inst_sram_wdata;
    inst_sram_addr_ok = sram_addr_ok & sram_req & (w_sel == SEL_INST);
    data_sram_addr_ok = sram_addr_ok & sram_req & (w_sel == SEL_DATA);
    inst_sram_data_ok = w_pop & resetn & (w_head == SEL_INST);
    data_sram_data_ok = w_pop & resetn & (w_head == SEL_DATA);
    inst_sram_rdata   = sram_rdata;
    data_sram_rdata   = sram_rdata;
    outstanding       = r_count;
    err_unexp_rsp     = r_err;
  end

  // Grant lock: a stalled request keeps the bus until its addr_ok.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lock       <= 1'b0;
      r_locked_sel <= SEL_INST;
    end else if (w_req && !sram_addr_ok) begin
      r_lock       <= 1'b1;
      r_locked_sel <= w_sel;
    end else if (w_push) begin
      r_lock       <= 1'b0;
    end
  end

  // Owner FIFO: push the granted port on accept, pop the head on response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) begin
        r_owner[r_wptr] <= w_sel;
        r_wptr          <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
    end
  end

  // Occupancy counter: unchanged when push and pop coincide.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err <= 1'b0;
    end else if (sram_data_ok && w_empty) begin
      r_err <= 1'b1;
    end
  end

endmodule
